// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake, persistent {C,F,Z,N,L} flag register
// and a WIDTH-cycle shift-add multiplier for MUL.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int OPW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    input  logic [OPW-1:0]   opcode,
    output logic [WIDTH-1:0] rout,
    output logic [4:0]       flags,
    output logic             done,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [OPW-1:0] OP_AND  = OPW'(8'h01);
    localparam logic [OPW-1:0] OP_OR   = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(8'h04);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(8'h05);
    localparam logic [OPW-1:0] OP_ADDU = OPW'(8'h06);
    localparam logic [OPW-1:0] OP_ADDC = OPW'(8'h07);
    localparam logic [OPW-1:0] OP_RSH  = OPW'(8'h08);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(8'h09);
    localparam logic [OPW-1:0] OP_SUBC = OPW'(8'h0A);
    localparam logic [OPW-1:0] OP_CMP  = OPW'(8'h0B);
    localparam logic [OPW-1:0] OP_ALSH = OPW'(8'h0C);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(8'h0E);
    localparam logic [OPW-1:0] OP_ARSH = OPW'(8'h0F);
    localparam logic [OPW-1:0] OP_LSH  = OPW'(8'h84);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic [4:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0] alu_res_s;
    logic [4:0]       alu_flags_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic             cin_s;
    logic [SHW-1:0]   sh_s;
    logic [WIDTH-1:0] acc_step_s;

    assign sh_s = r2[SHW-1:0];

    // Single-cycle datapath; flag bits are {C,F,Z,N,L}, untouched bits hold.
    always_comb begin
        alu_res_s   = '0;
        alu_flags_s = flags_q;
        if (opcode == OP_ADDC || opcode == OP_SUBC) begin
            cin_s = flags_q[4];
        end else begin
            cin_s = 1'b0;
        end
        sum_s  = {1'b0, r1} + {1'b0, r2} + {{WIDTH{1'b0}}, cin_s};
        diff_s = {1'b0, r1} - {1'b0, r2} - {{WIDTH{1'b0}}, cin_s};
        case (opcode)
            OP_AND:  alu_res_s = r1 & r2;
            OP_OR:   alu_res_s = r1 | r2;
            OP_XOR:  alu_res_s = r1 ^ r2;
            OP_NOT:  alu_res_s = ~r1;
            OP_ADD, OP_ADDU, OP_ADDC: begin
                alu_res_s      = sum_s[WIDTH-1:0];
                alu_flags_s[4] = sum_s[WIDTH];
                alu_flags_s[3] = (r1[MSB] == r2[MSB]) && (alu_res_s[MSB] != r1[MSB]);
                alu_flags_s[2] = (alu_res_s == '0);
            end
            OP_SUB, OP_SUBC: begin
                alu_res_s      = diff_s[WIDTH-1:0];
                alu_flags_s[4] = diff_s[WIDTH];
                alu_flags_s[3] = (r1[MSB] != r2[MSB]) && (alu_res_s[MSB] != r1[MSB]);
                alu_flags_s[2] = (alu_res_s == '0);
            end
            OP_CMP: begin
                alu_res_s      = diff_s[WIDTH-1:0];
                alu_flags_s[2] = (r1 == r2);
                alu_flags_s[1] = ($signed(r1) < $signed(r2));
                alu_flags_s[0] = (r1 < r2);
            end
            OP_RSH:          alu_res_s = r1 >> sh_s;
            OP_ARSH:         alu_res_s = $signed(r1) >>> sh_s;
            OP_ALSH, OP_LSH: alu_res_s = r1 << sh_s;
            default:         alu_res_s = '0;
        endcase
    end

    assign acc_step_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});

    // Handshake FSM: single-cycle ops stay in IDLE, MUL iterates one bit per cycle.
    always_comb begin
        state_d  = state_q;
        rout_d   = rout_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL) begin
                        mcand_d  = r1;
                        mplier_d = r2;
                        acc_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = S_MUL;
                    end else begin
                        rout_d  = alu_res_s;
                        flags_d = alu_flags_s;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d    = acc_step_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
                if (cnt_q == {SHW{1'b1}}) begin
                    rout_d  = acc_step_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_MUL;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset also aborts an in-flight MUL.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rout_q   <= '0;
            flags_q  <= 5'b00000;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rout_q   <= rout_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rout  = rout_q;
    assign flags = flags_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, parametrised successor to the combinational 16-bit ALU. It keeps the same opcode map and adds:
- generic datapath width
- a start/done handshake
- a persistent flag register (C, F, Z, N, L) that feeds ADDC/SUBC
- a multi-cycle shift-add multiplier for MUL

It sits between the register-file read ports and the writeback mux, and is driven by the control FSM.

Parameters:
WIDTH, 16, datapath width in bits (>= 4, power of 2)
OPW, 8, opcode width
SHW, $clog2(WIDTH), number of r2 LSBs used as shift amount (derived, not overridable)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; accepted only when busy=0
r1  in  WIDTH  operand A (sampled on accept)
r2  in  WIDTH  operand B (sampled on accept)
opcode  in  OPW  operation (sampled on accept)
rout  out  WIDTH  registered result
flags  out  5  {C,F,Z,N,L} registered flag register
done  out  1  one-cycle pulse: rout/flags valid this cycle
busy  out  1  high while a MUL is iterating

Behaviour:
- Reset (sync, active-high) sets rout=0, flags=0, done=0, busy=0, state=IDLE. It overrides start and aborts an in-flight MUL with no done pulse.
- States:
  - IDLE: on start=1 with a single-cycle opcode, compute, register rout/flags, pulse done the next cycle, stay in IDLE. This gives latency 1 and allows back-to-back issue every cycle.
  - IDLE -> MUL: on start=1 with opcode MUL, latch the operands, clear the accumulator, set busy=1.
  - MUL: one shift-add step per cycle for WIDTH cycles; start is ignored and inputs are not sampled.
  - MUL -> IDLE: after step WIDTH, rout = low WIDTH bits of the product, done=1 in that cycle, busy=0. Total latency is WIDTH+1 cycles from the accept edge.
- done=0 whenever no result completes. rout and flags hold their values between operations.
- Opcodes:
  - AND 0x01, OR 0x02, XOR 0x03: bitwise.
  - NOT 0x04: ~r1.
  - ADD 0x05: r1+r2.
  - ADDU 0x06: r1+r2.
  - ADDC 0x07: r1+r2+C.
  - RSH 0x08: logical right shift of r1 by r2[SHW-1:0].
  - SUB 0x09: r1-r2.
  - SUBC 0x0A: r1-r2-C.
  - CMP 0x0B: rout=r1-r2.
  - ALSH 0x0C and LSH 0x84: left shift of r1 by r2[SHW-1:0], zero fill.
  - MUL 0x0E: multi-cycle, see states above.
  - ARSH 0x0F: arithmetic right shift of r1 (sign fill).
- Arithmetic is modulo 2^WIDTH.
- Flags:
  - C = unsigned carry-out (add) or borrow (sub: 1 when r1 < r2+cin).
  - F = signed overflow.
  - Z = result==0.
  - N = r1<r2 signed (CMP only).
  - L = r1<r2 unsigned (CMP only).
  - ADD, ADDU, ADDC, SUB, SUBC update C, F, Z; N and L hold.
  - CMP updates Z (r1==r2), N, L; C and F hold.
  - Logic, shift, NOT and MUL leave all flags unchanged.
  - ADDC/SUBC use C as it was before the operation and then overwrite it.
- Unknown opcode: rout=0, flags unchanged, done still pulses (latency 1).
- Shift amount 0: rout=r1.

Test Plan:
1. Reset, then ADD r1=3, r2=1 -> rout=4, done high exactly 1 cycle after accept, flags C=0,F=0,Z=0.
2. ADD 0xFFFF+0x0001 -> rout=0x0000, C=1, Z=1, F=0. Next cycle ADDC 0x0001+0x0001 -> rout=0x0003, C=0.
3. ADD 0x7FFF+1 -> rout=0x8000, F=1, C=0. SUB 1-2 -> rout=0xFFFF, C=1, F=0.
4. CMP r1=0xFFFF (-1), r2=2 -> rout=0xFFFD, Z=0, N=1, L=0, C/F unchanged. CMP 1,1 -> Z=1, N=0, L=0.
5. MUL 300*300 -> busy high for 16 cycles, done at cycle 17, rout=0x5F90. A start pulse issued mid-MUL is ignored and produces no extra done.
6. ARSH 0x8000 by 3 -> 0xF000. RSH 0x8000 by 3 -> 0x1000. LSH 0x0001 by 15 -> 0x8000. Reset asserted mid-MUL -> rout=0, busy=0, no done. Repeat ADD at WIDTH=32: 0xFFFFFFFF+1 -> 0, C=1.
